// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear FSM driving a prescaled
// hundredths/seconds/minutes cascade with lap freeze and sticky overflow.
module stopwatch_ctrl #(
  parameter int unsigned DIV_MOD = 8'd10,
  parameter int unsigned CS_MOD  = 100,
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_start,
  input  logic                       btn_lap,
  input  logic                       btn_clear,
  output logic                       running,
  output logic                       frozen,
  output logic [$clog2(CS_MOD)-1:0]  cs,
  output logic [$clog2(SEC_MOD)-1:0] sec,
  output logic [$clog2(MIN_MOD)-1:0] min,
  output logic                       overflow,
  output logic [1:0]                 o_dbg_state
);

  localparam int unsigned PW   = $clog2(DIV_MOD);
  localparam int unsigned CS_W = $clog2(CS_MOD);
  localparam int unsigned S_W  = $clog2(SEC_MOD);
  localparam int unsigned M_W  = $clog2(MIN_MOD);

  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV_MOD - 1);
  localparam logic [CS_W-1:0] CS_MAX    = CS_W'(CS_MOD - 1);
  localparam logic [S_W-1:0]  SEC_MAX   = S_W'(SEC_MOD - 1);
  localparam logic [M_W-1:0]  MIN_MAX   = M_W'(MIN_MOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_running;
  logic            r_frozen;
  logic            r_overflow;
  logic [PW-1:0]   r_presc;
  logic [CS_W-1:0] r_cs;
  logic [S_W-1:0]  r_sec;
  logic [M_W-1:0]  r_min;
  logic [CS_W-1:0] r_frz_cs;
  logic [S_W-1:0]  r_frz_sec;
  logic [M_W-1:0]  r_frz_min;

  state_t w_next;
  logic   w_do_clear;
  logic   w_do_capture;
  logic   w_counting;
  logic   w_tick;

  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_presc == PRESC_MAX);

  // Buttons are single-cycle pulses; within a state the first legal button
  // in clear > start > lap order wins and the rest are dropped.
  always_comb begin
    w_next       = r_state;
    w_do_clear   = 1'b0;
    w_do_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (btn_start) w_next = S_RUN;
      end
      S_RUN: begin
        if (btn_start) begin
          w_next = S_PAUSE;
        end else if (btn_lap) begin
          w_next       = S_LAP;
          w_do_capture = 1'b1;
        end
      end
      S_LAP: begin
        if (btn_start)    w_next = S_PAUSE;
        else if (btn_lap) w_next = S_RUN;
      end
      S_PAUSE: begin
        if (btn_clear) begin
          w_next     = S_IDLE;
          w_do_clear = 1'b1;
        end else if (btn_start) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_frozen   <= 1'b0;
      r_overflow <= 1'b0;
      r_presc    <= '0;
      r_cs       <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_frz_cs   <= '0;
      r_frz_sec  <= '0;
      r_frz_min  <= '0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN) || (w_next == S_LAP);
      r_frozen  <= (w_next == S_LAP);
      if (w_do_clear) begin
        r_overflow <= 1'b0;
        r_presc    <= '0;
        r_cs       <= '0;
        r_sec      <= '0;
        r_min      <= '0;
        r_frz_cs   <= '0;
        r_frz_sec  <= '0;
        r_frz_min  <= '0;
      end else begin
        if (w_counting) begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
        // Cascade: a full-scale wrap leaves every field at zero and flags it.
        if (w_tick) begin
          if (r_cs == CS_MAX) begin
            r_cs <= '0;
            if (r_sec == SEC_MAX) begin
              r_sec <= '0;
              if (r_min == MIN_MAX) begin
                r_min      <= '0;
                r_overflow <= 1'b1;
              end else begin
                r_min <= r_min + 1'b1;
              end
            end else begin
              r_sec <= r_sec + 1'b1;
            end
          end else begin
            r_cs <= r_cs + 1'b1;
          end
        end
        if (w_do_capture) begin
          r_frz_cs  <= r_cs;
          r_frz_sec <= r_sec;
          r_frz_min <= r_min;
        end
      end
    end
  end

  assign running     = r_running;
  assign frozen      = r_frozen;
  assign overflow    = r_overflow;
  assign cs          = r_frozen ? r_frz_cs  : r_cs;
  assign sec         = r_frozen ? r_frz_sec : r_sec;
  assign min         = r_frozen ? r_frz_min : r_min;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: instance a uses DIV_MOD=4 with default
// moduli, instance b uses all moduli 2 to reach full-scale wrap quickly.
module tb_stopwatch_ctrl;

  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_RUN   = 32'd1;
  localparam logic [31:0] ST_PAUSE = 32'd2;
  localparam logic [31:0] ST_LAP   = 32'd3;

  logic       clk = 1'b0;
  logic       rst_a, start_a, lap_a, clr_a;
  logic       rst_b, start_b, lap_b, clr_b;
  logic       run_a, frz_a, ovf_a;
  logic [6:0] cs_a;
  logic [5:0] sec_a, min_a;
  logic [1:0] st_a;
  logic       run_b, frz_b, ovf_b;
  logic       cs_b, sec_b, min_b;
  logic [1:0] st_b;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIV_MOD(4)) dut_a (
    .clk(clk), .rst(rst_a), .btn_start(start_a), .btn_lap(lap_a), .btn_clear(clr_a),
    .running(run_a), .frozen(frz_a), .cs(cs_a), .sec(sec_a), .min(min_a),
    .overflow(ovf_a), .o_dbg_state(st_a)
  );

  stopwatch_ctrl #(.DIV_MOD(2), .CS_MOD(2), .SEC_MOD(2), .MIN_MOD(2)) dut_b (
    .clk(clk), .rst(rst_b), .btn_start(start_b), .btn_lap(lap_b), .btn_clear(clr_b),
    .running(run_b), .frozen(frz_b), .cs(cs_b), .sec(sec_b), .min(min_b),
    .overflow(ovf_b), .o_dbg_state(st_b)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic s, input logic l, input logic c);
    start_a = s; lap_a = l; clr_a = c;
    step(1);
    start_a = 1'b0; lap_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic pulse_b(input logic s, input logic l, input logic c);
    start_b = s; lap_b = l; clr_b = c;
    step(1);
    start_b = 1'b0; lap_b = 1'b0; clr_b = 1'b0;
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; lap_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; lap_b = 1'b0; clr_b = 1'b0;
    step(2);

    chk("rst_running", run_a, 0);
    chk("rst_frozen",  frz_a, 0);
    chk("rst_cs",      cs_a,  0);
    chk("rst_sec",     sec_a, 0);
    chk("rst_min",     min_a, 0);
    chk("rst_ovf",     ovf_a, 0);
    chk("rst_state",   st_a,  ST_IDLE);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(1);

    // lap and clear are ignored in IDLE
    pulse_a(1'b0, 1'b1, 1'b1);
    chk("idle_ignore_state", st_a,  ST_IDLE);
    chk("idle_ignore_frz",   frz_a, 0);

    // counting latency and one full second
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("start_running", run_a, 1);
    chk("start_cs0",     cs_a,  0);
    step(3);
    chk("lat_cs_edge3",  cs_a,  0);
    step(1);
    chk("lat_cs_edge4",  cs_a,  1);
    step(396);
    chk("count_sec", sec_a, 1);
    chk("count_cs",  cs_a,  0);
    chk("count_min", min_a, 0);

    // clear ignored while running
    pulse_a(1'b0, 1'b0, 1'b1);
    chk("run_clr_state", st_a,  ST_RUN);
    chk("run_clr_sec",   sec_a, 1);

    // reset mid-count
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    chk("midrst_running", run_a, 0);
    chk("midrst_cs",      cs_a,  0);
    chk("midrst_sec",     sec_a, 0);
    chk("midrst_min",     min_a, 0);
    chk("midrst_ovf",     ovf_a, 0);
    chk("midrst_state",   st_a,  ST_IDLE);

    // pause / resume: prescaler holds 3 across the pause
    pulse_a(1'b1, 1'b0, 1'b0);
    step(10);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("pause_state",   st_a,  ST_PAUSE);
    chk("pause_running", run_a, 0);
    chk("pause_cs",      cs_a,  2);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("pause_lap_ignored", st_a, ST_PAUSE);
    step(49);
    chk("pause_hold_cs", cs_a, 2);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("resume_edge_cs", cs_a, 2);
    step(2);
    chk("resume_cs", cs_a, 3);

    // pause then clear back to IDLE
    pulse_a(1'b1, 1'b0, 1'b0);
    pulse_a(1'b0, 1'b0, 1'b1);
    chk("clear_state", st_a, ST_IDLE);
    chk("clear_cs",    cs_a, 0);

    // lap freeze while live count continues
    pulse_a(1'b1, 1'b0, 1'b0);
    step(20);
    chk("prelap_cs", cs_a, 5);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("lap_frozen",  frz_a, 1);
    chk("lap_running", run_a, 1);
    chk("lap_cs",      cs_a,  5);
    step(40);
    chk("lap_hold_cs",  cs_a,  5);
    chk("lap_hold_frz", frz_a, 1);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("unlap_frozen", frz_a, 0);
    chk("unlap_cs",     cs_a,  15);
    chk("unlap_state",  st_a,  ST_RUN);

    // lap then start: tick on the transition edge still lands in live count
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("lap2_cs", cs_a, 15);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("lap_start_state", st_a,  ST_PAUSE);
    chk("lap_start_frz",   frz_a, 0);
    chk("lap_start_cs",    cs_a,  16);

    // priority: clear beats start in PAUSE
    pulse_a(1'b1, 1'b0, 1'b1);
    chk("prio_clr_state", st_a,  ST_IDLE);
    chk("prio_clr_run",   run_a, 0);
    chk("prio_clr_cs",    cs_a,  0);
    chk("prio_clr_sec",   sec_a, 0);

    // priority: start beats lap in RUN
    pulse_a(1'b1, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b1, 1'b0);
    chk("prio_sl_state", st_a,  ST_PAUSE);
    chk("prio_sl_frz",   frz_a, 0);
    chk("prio_sl_run",   run_a, 0);

    // full-scale wrap on small instance
    pulse_b(1'b1, 1'b0, 1'b0);
    step(14);
    chk("b_pre_cs",  cs_b,  1);
    chk("b_pre_sec", sec_b, 1);
    chk("b_pre_min", min_b, 1);
    chk("b_pre_ovf", ovf_b, 0);
    step(2);
    chk("b_ovf",     ovf_b, 1);
    chk("b_wrap_cs", cs_b,  0);
    chk("b_wrap_sec", sec_b, 0);
    chk("b_wrap_min", min_b, 0);
    chk("b_running", run_b, 1);
    step(5);
    chk("b_ovf_sticky", ovf_b, 1);
    pulse_b(1'b1, 1'b0, 1'b0);
    pulse_b(1'b0, 1'b0, 1'b1);
    chk("b_clr_ovf",   ovf_b, 0);
    chk("b_clr_state", st_b,  ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
